// File: rtl/canvas_arbiter_if.sv
// Canvas arbiter bus bundle.
// Groups the display read port, mouse-draw write port, classifier read port,
// clear control, and the single-port RAM command/response signals.
//   slave  : arbiter side (takes requests, drives grants/read data/RAM command)
//   master : environment side (clients plus RAM model)
interface canvas_arbiter_if #(
  parameter int AW = 10
);
  // display read port
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic          disp_pixel;
  // mouse-draw write port
  logic          draw_req;
  logic [AW-1:0] draw_addr;
  logic          draw_data;
  logic          draw_gnt;
  // classifier read port
  logic          cls_req;
  logic [AW-1:0] cls_addr;
  logic          cls_gnt;
  logic          cls_rvalid;
  logic          cls_pixel;
  // clear control
  logic          clear_start;
  logic          clear_busy;
  // single-port RAM
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_wdata;
  logic          mem_rdata;

  modport slave (
    input  disp_req, disp_addr, draw_req, draw_addr, draw_data,
           cls_req, cls_addr, clear_start, mem_rdata,
    output disp_rvalid, disp_pixel, draw_gnt, cls_gnt, cls_rvalid, cls_pixel,
           clear_busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, draw_req, draw_addr, draw_data,
           cls_req, cls_addr, clear_start, mem_rdata,
    input  disp_rvalid, disp_pixel, draw_gnt, cls_gnt, cls_rvalid, cls_pixel,
           clear_busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/canvas_arbiter.sv
// Canvas RAM arbiter: shares one single-port 1-bit RAM between the display
// reader (highest priority, never stalled), a clear sweep, and a round-robin
// pair of mouse-draw writer and classifier reader.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - canvas_arbiter_if.slave (request/grant/read-data ports + RAM command)
module canvas_arbiter #(
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  canvas_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rr_q, rr_d;         // 0: draw wins next contest, 1: classify wins
  logic          disp_rvalid_q, disp_hit_q;
  logic          cls_rvalid_q, cls_hit_q;
  logic          draw_gnt, cls_gnt;
  logic          disp_inr, draw_inr, cls_inr;

  assign disp_inr = {1'b0, bus.disp_addr} < DEPTH_C;
  assign draw_inr = {1'b0, bus.draw_addr} < DEPTH_C;
  assign cls_inr  = {1'b0, bus.cls_addr}  < DEPTH_C;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    rr_d          = rr_q;
    draw_gnt      = 1'b0;
    cls_gnt       = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 1'b0;

    if (bus.disp_req) begin
      if (disp_inr) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.disp_addr;
      end
    end else if (state_q == CLEAR) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_addr = clr_cnt_q;
      if (clr_cnt_q == LAST_C) begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
    end else begin
      if (bus.draw_req && (!bus.cls_req || !rr_q)) begin
        draw_gnt = 1'b1;
        rr_d     = 1'b1;
        if (draw_inr) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.draw_addr;
          bus.mem_wdata = bus.draw_data;
        end
      end else if (bus.cls_req) begin
        cls_gnt = 1'b1;
        rr_d    = 1'b0;
        if (cls_inr) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.cls_addr;
        end
      end
    end

    // A start pulse during an active sweep is ignored: only IDLE reacts.
    if (state_q == IDLE && bus.clear_start) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      rr_q          <= 1'b0;
      disp_rvalid_q <= 1'b0;
      disp_hit_q    <= 1'b0;
      cls_rvalid_q  <= 1'b0;
      cls_hit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      rr_q          <= rr_d;
      disp_rvalid_q <= bus.disp_req;
      disp_hit_q    <= bus.disp_req & disp_inr;
      cls_rvalid_q  <= cls_gnt;
      cls_hit_q     <= cls_gnt & cls_inr;
    end
  end

  // RAM data arrives in the rvalid cycle, so pixels are mem_rdata gated by the
  // registered "real RAM read" flags; out-of-range reads and reset yield 0.
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.disp_pixel  = disp_hit_q & bus.mem_rdata;
  assign bus.cls_rvalid  = cls_rvalid_q;
  assign bus.cls_pixel   = cls_hit_q & bus.mem_rdata;
  assign bus.draw_gnt    = draw_gnt;
  assign bus.cls_gnt     = cls_gnt;
  assign bus.clear_busy  = (state_q == CLEAR);

endmodule

// File: tb/tb_canvas_arbiter.sv
module tb_canvas_arbiter;
  localparam int DEPTH = 784;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  canvas_arbiter_if #(.AW(AW)) bus();
  canvas_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // RAM model plus sweep monitors
  logic mem [0:1023];
  logic fill_ones = 1'b0;
  int   zero_wr   = 0;
  int   gnt_busy  = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always @(posedge clk) begin
    if (fill_ones) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
    if (bus.clear_busy && bus.mem_en && bus.mem_we && !bus.mem_wdata) zero_wr++;
    if (bus.clear_busy && (bus.draw_gnt || bus.cls_gnt)) gnt_busy++;
  end

  function automatic int count_zeros(int lo, int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (mem[i] === 1'b0) n++;
    return n;
  endfunction

  task automatic idle_inputs();
    bus.disp_req = 0; bus.disp_addr = '0; bus.draw_req = 0; bus.draw_addr = '0;
    bus.draw_data = 0; bus.cls_req = 0; bus.cls_addr = '0; bus.clear_start = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    fill_ones = 1'b1;
    @(posedge clk); #1 fill_ones = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.disp_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_disp_rvalid got=%b exp=0", bus.disp_rvalid); end
    tests_run++; if (bus.cls_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_cls_rvalid got=%b exp=0", bus.cls_rvalid); end
    tests_run++; if (bus.clear_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_clear_busy got=%b exp=0", bus.clear_busy); end
    tests_run++; if (bus.disp_pixel !== 1'b0 || bus.cls_pixel !== 1'b0) begin tests_failed++; $display("FAIL reset_pixels got=%b%b exp=00", bus.disp_pixel, bus.cls_pixel); end
    tests_run++; if (bus.mem_en !== 1'b0 || bus.mem_addr !== '0) begin tests_failed++; $display("FAIL reset_mem_idle got en=%b addr=%0d exp en=0 addr=0", bus.mem_en, bus.mem_addr); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.draw_req = 1; bus.draw_addr = 20; bus.draw_data = 1;
        bus.cls_req = 1; bus.cls_addr = 5;
      end
      @(negedge clk);
      tests_run++; if (bus.draw_gnt !== (i % 2 == 0)) begin tests_failed++; $display("FAIL rr_draw_gnt[%0d] got=%b exp=%b", i, bus.draw_gnt, (i % 2 == 0)); end
      tests_run++; if (bus.cls_gnt !== (i % 2 == 1)) begin tests_failed++; $display("FAIL rr_cls_gnt[%0d] got=%b exp=%b", i, bus.cls_gnt, (i % 2 == 1)); end
      tests_run++; if (bus.cls_rvalid !== (i == 2)) begin tests_failed++; $display("FAIL rr_cls_rvalid[%0d] got=%b exp=%b", i, bus.cls_rvalid, (i == 2)); end
    end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    tests_run++; if (bus.cls_rvalid !== 1'b1 || bus.cls_pixel !== 1'b1) begin tests_failed++; $display("FAIL rr_last_read got v=%b p=%b exp v=1 p=1", bus.cls_rvalid, bus.cls_pixel); end
  endtask

  task automatic test_disp_priority();
    @(posedge clk); #1;
    bus.disp_req = 1; bus.disp_addr = 5;
    bus.draw_req = 1; bus.draw_addr = 10; bus.draw_data = 0;
    @(negedge clk);
    tests_run++; if (bus.draw_gnt !== 1'b0) begin tests_failed++; $display("FAIL prio_draw_blocked got=%b exp=0", bus.draw_gnt); end
    tests_run++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'd5) begin tests_failed++; $display("FAIL prio_disp_cmd got en=%b we=%b addr=%0d exp en=1 we=0 addr=5", bus.mem_en, bus.mem_we, bus.mem_addr); end
    @(posedge clk); #1 bus.disp_req = 0;
    @(negedge clk);
    tests_run++; if (bus.draw_gnt !== 1'b1) begin tests_failed++; $display("FAIL prio_draw_next got=%b exp=1", bus.draw_gnt); end
    tests_run++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd10 || bus.mem_wdata !== 1'b0) begin tests_failed++; $display("FAIL prio_draw_cmd got we=%b addr=%0d d=%b exp we=1 addr=10 d=0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    tests_run++; if (bus.disp_rvalid !== 1'b1 || bus.disp_pixel !== 1'b1) begin tests_failed++; $display("FAIL prio_disp_data got v=%b p=%b exp v=1 p=1", bus.disp_rvalid, bus.disp_pixel); end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    tests_run++; if (bus.disp_rvalid !== 1'b0) begin tests_failed++; $display("FAIL prio_disp_rvalid_drop got=%b exp=0", bus.disp_rvalid); end
  endtask

  task automatic test_clear_alternate();
    int z0, g0, busy;
    bit done;
    z0 = zero_wr; g0 = gnt_busy; busy = 0; done = 0;
    @(posedge clk); #1;
    bus.clear_start = 1;
    bus.draw_req = 1; bus.draw_addr = 784; bus.draw_data = 1;
    bus.cls_req = 1; bus.cls_addr = 784;
    @(negedge clk);
    tests_run++; if (bus.clear_busy !== 1'b0) begin tests_failed++; $display("FAIL clr_busy_early got=%b exp=0", bus.clear_busy); end
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      bus.clear_start = 0; bus.disp_req = (i % 2 == 0); bus.disp_addr = 5;
      @(negedge clk);
      if (bus.clear_busy) busy++; else done = 1;
    end
    @(posedge clk); #1 idle_inputs();
    tests_run++; if (!done) begin tests_failed++; $display("FAIL clr_timeout got busy_cycles=%0d exp sweep end", busy); end
    tests_run++; if (zero_wr - z0 != 784) begin tests_failed++; $display("FAIL clr_zero_writes got=%0d exp=784", zero_wr - z0); end
    tests_run++; if (busy < 1567 || busy > 1568) begin tests_failed++; $display("FAIL clr_busy_cycles got=%0d exp=1567..1568", busy); end
    tests_run++; if (gnt_busy - g0 != 0) begin tests_failed++; $display("FAIL clr_grants_in_sweep got=%0d exp=0", gnt_busy - g0); end
    tests_run++; if (count_zeros(0, 783) != 784) begin tests_failed++; $display("FAIL clr_cells_zero got=%0d exp=784", count_zeros(0, 783)); end
  endtask

  task automatic test_boundary();
    @(posedge clk); #1;
    bus.draw_req = 1; bus.draw_addr = 783; bus.draw_data = 1;
    @(negedge clk);
    tests_run++; if (bus.draw_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd783) begin tests_failed++; $display("FAIL bnd_write783 got g=%b en=%b addr=%0d exp g=1 en=1 addr=783", bus.draw_gnt, bus.mem_en, bus.mem_addr); end
    @(posedge clk); #1;
    bus.draw_req = 0; bus.cls_req = 1; bus.cls_addr = 783;
    @(negedge clk);
    tests_run++; if (bus.cls_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL bnd_read783_cmd got g=%b en=%b we=%b exp g=1 en=1 we=0", bus.cls_gnt, bus.mem_en, bus.mem_we); end
    @(posedge clk); #1 bus.cls_addr = 784;
    @(negedge clk);
    tests_run++; if (bus.cls_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin tests_failed++; $display("FAIL bnd_read784_cmd got g=%b en=%b exp g=1 en=0", bus.cls_gnt, bus.mem_en); end
    tests_run++; if (bus.cls_rvalid !== 1'b1 || bus.cls_pixel !== 1'b1) begin tests_failed++; $display("FAIL bnd_read783_data got v=%b p=%b exp v=1 p=1", bus.cls_rvalid, bus.cls_pixel); end
    @(posedge clk); #1;
    bus.cls_req = 0; bus.draw_req = 1; bus.draw_addr = 1000; bus.draw_data = 1;
    @(negedge clk);
    tests_run++; if (bus.cls_rvalid !== 1'b1 || bus.cls_pixel !== 1'b0) begin tests_failed++; $display("FAIL bnd_read784_data got v=%b p=%b exp v=1 p=0", bus.cls_rvalid, bus.cls_pixel); end
    tests_run++; if (bus.draw_gnt !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_addr !== '0) begin tests_failed++; $display("FAIL bnd_write_oor got g=%b en=%b addr=%0d exp g=1 en=0 addr=0", bus.draw_gnt, bus.mem_en, bus.mem_addr); end
    @(posedge clk); #1 idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    int z0, n;
    @(posedge clk); #1 fill_ones = 1;
    @(posedge clk); #1 fill_ones = 0; bus.clear_start = 1;
    z0 = zero_wr;
    @(posedge clk); #1 bus.clear_start = 0;
    n = 0;
    while (zero_wr - z0 < 300 && n < 1000) begin @(negedge clk); n++; end
    tests_run++; if (n >= 1000) begin tests_failed++; $display("FAIL rstclr_timeout got writes=%0d exp=300", zero_wr - z0); end
    rst = 0;
    #1;
    tests_run++; if (bus.clear_busy !== 1'b0) begin tests_failed++; $display("FAIL rstclr_busy got=%b exp=0", bus.clear_busy); end
    tests_run++; if (count_zeros(0, 299) != 300) begin tests_failed++; $display("FAIL rstclr_low_cells got=%0d zeros exp=300", count_zeros(0, 299)); end
    tests_run++; if (count_zeros(300, 783) != 0) begin tests_failed++; $display("FAIL rstclr_high_cells got=%0d zeros exp=0", count_zeros(300, 783)); end
    @(posedge clk); #1 rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.clear_busy !== 1'b0) begin tests_failed++; $display("FAIL rstclr_no_resume got=%b exp=0", bus.clear_busy); end
    @(posedge clk); #1 bus.cls_req = 1; bus.cls_addr = 300;
    @(posedge clk); #1 bus.cls_addr = 299;
    @(negedge clk);
    tests_run++; if (bus.cls_rvalid !== 1'b1 || bus.cls_pixel !== 1'b1) begin tests_failed++; $display("FAIL rstclr_read300 got v=%b p=%b exp v=1 p=1", bus.cls_rvalid, bus.cls_pixel); end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    tests_run++; if (bus.cls_rvalid !== 1'b1 || bus.cls_pixel !== 1'b0) begin tests_failed++; $display("FAIL rstclr_read299 got v=%b p=%b exp v=1 p=0", bus.cls_rvalid, bus.cls_pixel); end
  endtask

  task automatic test_restart_ignored();
    int z0, n;
    @(posedge clk); #1 fill_ones = 1;
    @(posedge clk); #1 fill_ones = 0; bus.clear_start = 1;
    z0 = zero_wr;
    @(posedge clk); #1 bus.clear_start = 0;
    n = 0;
    while (zero_wr - z0 < 100 && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.clear_start = 1;
    @(posedge clk); #1 bus.clear_start = 0;
    n = 0;
    @(negedge clk);
    while (bus.clear_busy && n < 2000) begin @(negedge clk); n++; end
    tests_run++; if (n >= 2000) begin tests_failed++; $display("FAIL restart_timeout got busy=%b exp=0", bus.clear_busy); end
    tests_run++; if (zero_wr - z0 != 784) begin tests_failed++; $display("FAIL restart_writes got=%0d exp=784", zero_wr - z0); end
    tests_run++; if (count_zeros(0, 783) != 784) begin tests_failed++; $display("FAIL restart_cells_zero got=%0d exp=784", count_zeros(0, 783)); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_disp_priority();
    test_clear_alternate();
    test_boundary();
    test_reset_mid_clear();
    test_restart_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/canvas_arbiter.md
CANVAS_ARBITER -- requirements
Module: canvas_arbiter

Interface
REQ-001 Parameter DEPTH, default 784, number of 1-bit canvas cells (28x28).
REQ-002 Parameter AW, default 10, address width; SHALL satisfy 2^AW >= DEPTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 disp_req  input  1  display read request for the current cycle; needs no handshake.
REQ-006 disp_addr  input  AW  display cell address.
REQ-007 disp_rvalid  output  1  display read data valid.
REQ-008 disp_pixel  output  1  display read data (feeds canvas_pixel).
REQ-009 draw_req  input  1  mouse-draw write request; held high until granted.
REQ-010 draw_addr / draw_data  input  AW / 1  write address and value, stable while draw_req is high.
REQ-011 draw_gnt  output  1  one-cycle pulse; the write is accepted in this cycle.
REQ-012 cls_req / cls_addr  input  1 / AW  classifier read request, held until granted, and its address.
REQ-013 cls_gnt  output  1  one-cycle pulse; the classifier read is accepted in this cycle.
REQ-014 cls_rvalid / cls_pixel  output  1 / 1  classifier read data valid and data.
REQ-015 clear_start  input  1  pulse; requests a clear of all cells to 0.
REQ-016 clear_busy  output  1  high while a clear sweep is in progress.
REQ-017 mem_en / mem_we / mem_addr / mem_wdata  output  1/1/AW/1  single-port RAM command.
REQ-018 mem_rdata  input  1  RAM read data, valid the cycle after a read command.

Function
REQ-019 The block SHALL issue at most one RAM access per cycle.
REQ-020 Priority SHALL be: display, then clear sweep, then draw/classify.
REQ-021 Draw and classify SHALL alternate round-robin; after one of them is granted, the other wins the next contested cycle.
REQ-022 The round-robin pointer SHALL reset to favour draw.
REQ-023 A granted draw SHALL drive mem_en=1, mem_we=1, mem_addr=draw_addr, mem_wdata=draw_data in the grant cycle.
REQ-024 A granted read (display or classify) SHALL drive mem_en=1, mem_we=0; the matching rvalid SHALL assert exactly one cycle later, and pixel SHALL equal mem_rdata.
REQ-025 Read latency SHALL be 1 cycle from request/grant to rvalid; disp_req SHALL always be served in its own cycle.
REQ-026 A request with address >= DEPTH SHALL still be granted, but no RAM access SHALL occur; a read SHALL return pixel=0 with normal rvalid timing, and a write SHALL be dropped.
REQ-027 FSM states SHALL be IDLE and CLEAR.
REQ-028 IDLE -> CLEAR on clear_start: the clear counter loads 0 and clear_busy=1 from the next cycle.
REQ-029 In CLEAR, each cycle without disp_req SHALL write 0 to the counter address and increment the counter; display cycles SHALL stall the counter.
REQ-030 CLEAR -> IDLE after address DEPTH-1 is written; clear_busy SHALL deassert the following cycle.
REQ-031 While in CLEAR, draw_gnt and cls_gnt SHALL be 0; pending requests wait.
REQ-032 clear_start while already in CLEAR SHALL be ignored (no restart).
REQ-033 When no access is granted, the block SHALL drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Grant outputs SHALL be combinational from the current requests and state; rvalid/pixel outputs SHALL be registered.

Reset
REQ-035 On rst=0, asynchronously: FSM=IDLE, clear counter=0, clear_busy=0, all rvalid=0, all pixel=0, and any pending read return SHALL be discarded.
REQ-036 A reset during CLEAR SHALL abort the sweep; cells already cleared stay cleared, and no resumption SHALL occur.

Verification
REQ-037 disp_req=1 with addr 5 and draw_req=1 in the same cycle -> the display is served, draw_gnt=0; draw_gnt=1 in the next cycle with disp_req=0.
REQ-038 draw_req and cls_req held together for 4 idle cycles -> grants go draw, cls, draw, cls; cls_rvalid is 1 cycle after each cls_gnt.
REQ-039 Write 1 to addr 783, then a classify read of 783 -> cls_pixel=1; a read of addr 784 -> cls_pixel=0 with no mem_en.
REQ-040 clear_start with disp_req asserted on alternate cycles -> 784 zero writes, clear_busy high for 1567-1568 cycles, no draw/cls grants during the sweep.
REQ-041 rst=0 midway through a clear (counter=300) -> clear_busy=0 immediately; after release, cells 0-299 read 0 and cells 300+ keep their prior values.
REQ-042 clear_start pulsed again at counter=100 -> the sweep finishes at 783 without restarting.
